// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multicycle
//  Description : Multi-cycle MIPS-style ALU with a start/done handshake.
//                AND/OR/ADD/SUB/SLTU/SLT complete one cycle after accept when
//                FAST_OPS=1. MUL uses iterative shift-add into a 2*n_bits
//                accumulator. DIVU uses restoring division, one quotient bit
//                per cycle. Results are registered and held between done
//                pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_multicycle #(
  parameter int n_bits   = 32,
  parameter bit FAST_OPS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        ALUControl,
  input  logic [n_bits-1:0] srca,
  input  logic [n_bits-1:0] srcb,
  output logic              busy,
  output logic              done,
  output logic [n_bits-1:0] ALUResult,
  output logic [n_bits-1:0] ALUResultHi,
  output logic              Zero,
  output logic              DivByZero
);

  localparam logic [2:0] c_op_and  = 3'b000;
  localparam logic [2:0] c_op_or   = 3'b001;
  localparam logic [2:0] c_op_add  = 3'b010;
  localparam logic [2:0] c_op_divu = 3'b011;
  localparam logic [2:0] c_op_sub  = 3'b100;
  localparam logic [2:0] c_op_mul  = 3'b101;
  localparam logic [2:0] c_op_sltu = 3'b110;
  localparam logic [2:0] c_op_slt  = 3'b111;

  // The iteration counter runs 0 .. n_bits-1. The last iteration writes the
  // result directly, so the CALC phase is exactly n_bits cycles long.
  localparam int                 c_cnt_w = $clog2(n_bits);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(n_bits - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_direct;
  logic                  w_direct_op;
  logic                  w_finish;

  logic [2:0]            r_op;
  logic [n_bits-1:0]     r_a;
  logic [n_bits-1:0]     r_b;
  logic [2*n_bits-1:0]   r_acc;
  logic [c_cnt_w-1:0]    r_cnt;

  logic [n_bits:0]       w_mul_sum;
  logic [2*n_bits-1:0]   w_mul_next;
  logic [n_bits:0]       w_div_shift;
  logic                  w_div_ge;
  logic [n_bits-1:0]     w_div_sub;
  logic [2*n_bits-1:0]   w_div_next;
  logic [2*n_bits-1:0]   w_acc_next;
  logic [n_bits-1:0]     w_fast_in;
  logic [n_bits-1:0]     w_fin_lo;
  logic [n_bits-1:0]     w_fin_hi;

  logic [n_bits-1:0]     r_result;
  logic [n_bits-1:0]     r_result_hi;
  logic                  r_zero;
  logic                  r_div_by_zero;

  // Single-cycle operations; MUL/DIVU are not handled here.
  function automatic logic [n_bits-1:0] f_fast(input logic [2:0]        op,
                                               input logic [n_bits-1:0] a,
                                               input logic [n_bits-1:0] b);
    logic [n_bits-1:0] v;
    v = '0;
    case (op)
      c_op_and:  v = a & b;
      c_op_or:   v = a | b;
      c_op_add:  v = a + b;
      c_op_sub:  v = a - b;
      c_op_sltu: v = {{(n_bits-1){1'b0}}, (a < b)};
      c_op_slt:  v = {{(n_bits-1){1'b0}}, ($signed(a) < $signed(b))};
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Operations that finish on the accept edge without entering CALC.
  // Divide by zero always takes this path so the error is reported at once.
  always_comb begin
    w_direct_op = 1'b0;
    if ((ALUControl == c_op_divu) && (srcb == '0)) begin
      w_direct_op = 1'b1;
    end else if (FAST_OPS && (ALUControl != c_op_mul) && (ALUControl != c_op_divu)) begin
      w_direct_op = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, handshake decode and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_direct     = 1'b0;
    w_finish     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done         = (r_state == S_DONE);
        w_state_next = S_IDLE;
        if (start) begin
          w_accept     = 1'b1;
          w_direct     = w_direct_op;
          w_state_next = w_direct_op ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == c_last) begin
          w_finish     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide. The low half of
  // the accumulator holds the remaining multiplier bits (MUL) or the
  // not-yet-consumed dividend bits that become the quotient (DIVU).
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*n_bits-1:n_bits]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_mul_next  = {w_mul_sum, r_acc[n_bits-1:1]};
    w_div_shift = r_acc[2*n_bits-1:n_bits-1];
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    w_div_sub   = w_div_shift[n_bits-1:0] - r_b;
    w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[n_bits-1:0]),
                   r_acc[n_bits-2:0], w_div_ge};
    w_acc_next  = r_acc;
    if (r_op == c_op_mul) begin
      w_acc_next = w_mul_next;
    end else if (r_op == c_op_divu) begin
      w_acc_next = w_div_next;
    end
  end

  // Result selection for the direct path and for the final CALC cycle.
  always_comb begin
    w_fast_in = f_fast(ALUControl, srca, srcb);
    w_fin_lo  = f_fast(r_op, r_a, r_b);
    w_fin_hi  = '0;
    if (r_op == c_op_mul) begin
      w_fin_lo = w_mul_next[n_bits-1:0];
      w_fin_hi = w_mul_next[2*n_bits-1:n_bits];
    end else if (r_op == c_op_divu) begin
      w_fin_lo = w_div_next[n_bits-1:0];
      w_fin_hi = w_div_next[2*n_bits-1:n_bits];
    end
  end

  // Operand capture at accept, then one iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= c_op_and;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= ALUControl;
      r_a   <= srca;
      r_b   <= srcb;
      r_cnt <= '0;
      if (ALUControl == c_op_mul) begin
        r_acc <= {{n_bits{1'b0}}, srcb};
      end else begin
        r_acc <= {{n_bits{1'b0}}, srca};
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
    end
  end

  // Architectural outputs change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result      <= '0;
      r_result_hi   <= '0;
      r_zero        <= 1'b1;
      r_div_by_zero <= 1'b0;
    end else if (w_direct) begin
      if (ALUControl == c_op_divu) begin
        r_result      <= '1;
        r_result_hi   <= srca;
        r_zero        <= 1'b0;
        r_div_by_zero <= 1'b1;
      end else begin
        r_result      <= w_fast_in;
        r_result_hi   <= '0;
        r_zero        <= (w_fast_in == '0);
        r_div_by_zero <= 1'b0;
      end
    end else if (w_finish) begin
      r_result      <= w_fin_lo;
      r_result_hi   <= w_fin_hi;
      r_zero        <= (w_fin_lo == '0);
      r_div_by_zero <= 1'b0;
    end
  end

  assign ALUResult   = r_result;
  assign ALUResultHi = r_result_hi;
  assign Zero        = r_zero;
  assign DivByZero   = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_multicycle
//  Description : Self-checking bench for alu_multicycle (n_bits=32). An
//                operation-level model predicts busy/done/results each cycle;
//                directed sequences add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_multicycle;

  localparam int c_n = 32;

  localparam logic [2:0] c_and  = 3'b000;
  localparam logic [2:0] c_or   = 3'b001;
  localparam logic [2:0] c_add  = 3'b010;
  localparam logic [2:0] c_divu = 3'b011;
  localparam logic [2:0] c_sub  = 3'b100;
  localparam logic [2:0] c_mul  = 3'b101;
  localparam logic [2:0] c_sltu = 3'b110;
  localparam logic [2:0] c_slt  = 3'b111;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      ALUControl;
  logic [c_n-1:0]  srca;
  logic [c_n-1:0]  srcb;
  logic            busy;
  logic            done;
  logic [c_n-1:0]  ALUResult;
  logic [c_n-1:0]  ALUResultHi;
  logic            Zero;
  logic            DivByZero;

  int n_pass  = 0;
  int n_total = 0;

  alu_multicycle #(.n_bits(c_n), .FAST_OPS(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ALUControl  (ALUControl),
    .srca        (srca),
    .srcb        (srcb),
    .busy        (busy),
    .done        (done),
    .ALUResult   (ALUResult),
    .ALUResultHi (ALUResultHi),
    .Zero        (Zero),
    .DivByZero   (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  typedef struct packed {
    logic          dbz;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [7:0]    lat;
  } res_t;

  // What an operation must produce, straight from the arithmetic definition.
  function automatic res_t model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [63:0] p;
    r = '0;
    r.lat = 8'd1;
    case (op)
      c_and:  r.lo = a & b;
      c_or:   r.lo = a | b;
      c_add:  r.lo = a + b;
      c_sub:  r.lo = a - b;
      c_sltu: r.lo = (a < b) ? 32'd1 : 32'd0;
      c_slt:  r.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      c_mul: begin
        p = {32'd0, a} * {32'd0, b};
        r.lo = p[31:0];
        r.hi = p[63:32];
        r.lat = 8'(c_n + 1);
      end
      default: begin
        if (b == 32'd0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = a;
          r.dbz = 1'b1;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
          r.lat = 8'(c_n + 1);
        end
      end
    endcase
    return r;
  endfunction

  // Cycle model: edge k is counted between negedges; accepted ops become
  // visible on edge accept+lat-1 and busy covers the edges in between.
  initial begin : model
    int   k;
    int   d_edge;
    int   done_edge;
    logic pending;
    res_t pend;
    res_t vis;
    logic l_rst, l_start;
    logic [2:0] l_op;
    logic [31:0] l_a, l_b;
    k = 0; d_edge = 0; done_edge = -5; pending = 1'b0;
    pend = '0; vis = '0;
    l_rst = 1'b0; l_start = 1'b0; l_op = '0; l_a = '0; l_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending   = 1'b0;
        vis       = '0;
        done_edge = -5;
      end else if (l_rst) begin
        k++;
        if (l_start && !pending) begin
          pend    = model_op(l_op, l_a, l_b);
          d_edge  = k + int'(pend.lat) - 1;
          pending = 1'b1;
        end
        if (pending && (k == d_edge)) begin
          vis       = pend;
          pending   = 1'b0;
          done_edge = k;
        end
      end
      check("cyc_done",  64'(done),        64'(rst_n && (done_edge == k)));
      check("cyc_busy",  64'(busy),        64'(pending));
      check("cyc_lo",    64'(ALUResult),   64'(vis.lo));
      check("cyc_hi",    64'(ALUResultHi), 64'(vis.hi));
      check("cyc_zero",  64'(Zero),        64'(vis.lo == 32'd0));
      check("cyc_dbz",   64'(DivByZero),   64'(vis.dbz));
      l_rst = rst_n; l_start = start; l_op = ALUControl; l_a = srca; l_b = srcb;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl = op; srca = a; srcb = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns cycles from accept edge to done (from = cycles already elapsed); -1 on timeout.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    if (!done) lat = -1;
  endtask

  initial begin : stim
    int lat;
    int n_done;
    rst_n = 1'b1; start = 1'b0; ALUControl = c_and; srca = '0; srcb = '0;
    #2 rst_n = 1'b0;
    tick(); tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo",   64'(ALUResult), 64'd0);
    check("rst_zero", 64'(Zero), 64'd1);
    rst_n = 1'b1;
    tick();

    // reset during MUL aborts it
    issue(c_add, 32'd3, 32'd4);
    wait_done(1, lat);
    check("add34_lo", 64'(ALUResult), 64'd7);
    issue(c_mul, 32'hFFFF_FFFF, 32'd2);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_lo",   64'(ALUResult), 64'd0);
    check("midrst_zero", 64'(Zero), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n_done++;
    end
    check("midrst_nodone", 64'(n_done), 64'd0);

    issue(c_add, 32'hFFFF_FFFF, 32'd1);
    wait_done(1, lat);
    check("add_wrap_lat",  64'(lat), 64'd1);
    check("add_wrap_lo",   64'(ALUResult), 64'd0);
    check("add_wrap_zero", 64'(Zero), 64'd1);
    issue(c_sub, 32'd5, 32'd7);
    wait_done(1, lat);
    check("sub_lo",   64'(ALUResult), 64'hFFFF_FFFE);
    check("sub_zero", 64'(Zero), 64'd0);

    issue(c_mul, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_hi",  64'(ALUResultHi), 64'hFFFF_FFFE);
    check("mul_lo",  64'(ALUResult), 64'h0000_0001);

    issue(c_divu, 32'd100, 32'd7);
    wait_done(1, lat);
    check("div_lat", 64'(lat), 64'd33);
    check("div_q",   64'(ALUResult), 64'd14);
    check("div_r",   64'(ALUResultHi), 64'd2);
    issue(c_divu, 32'd9, 32'd0);
    wait_done(1, lat);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_q",   64'(ALUResult), 64'hFFFF_FFFF);
    check("div0_r",   64'(ALUResultHi), 64'd9);
    check("div0_dbz", 64'(DivByZero), 64'd1);

    issue(c_slt, 32'hFFFF_FFFF, 32'd1);
    wait_done(1, lat);
    check("slt_lo", 64'(ALUResult), 64'd1);
    issue(c_sltu, 32'hFFFF_FFFF, 32'd1);
    wait_done(1, lat);
    check("sltu_lo",   64'(ALUResult), 64'd0);
    check("sltu_zero", 64'(Zero), 64'd1);

    // start while busy is dropped; operand change mid-CALC has no effect
    issue(c_mul, 32'h0001_2345, 32'h0000_0100);
    tick(); tick(); tick();
    ALUControl = c_add; srca = 32'd1; srcb = 32'd1; start = 1'b1;
    tick();
    start = 1'b0; srca = 32'hDEAD_BEEF;
    check("ign_busy", 64'(busy), 64'd1);
    check("ign_prev", 64'(ALUResult), 64'd0);
    wait_done(5, lat);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_lo",  64'(ALUResult), 64'h0123_4500);
    check("ign_hi",  64'(ALUResultHi), 64'd0);
    tick();
    check("ign_nodone", 64'(done), 64'd0);

    // back-to-back: start held through the DONE cycle
    ALUControl = c_add; srca = 32'd2; srcb = 32'd3; start = 1'b1;
    tick();
    check("b2b_done1", 64'(done), 64'd1);
    check("b2b_lo1",   64'(ALUResult), 64'd5);
    ALUControl = c_sub; srca = 32'd10; srcb = 32'd4;
    tick();
    start = 1'b0;
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_lo2",   64'(ALUResult), 64'd6);
    tick();
    check("b2b_idle", 64'(done), 64'd0);

    issue(c_and, 32'h0000_F0F0, 32'h0000_FF00);
    wait_done(1, lat);
    check("and_lo", 64'(ALUResult), 64'h0000_F000);
    issue(c_or, 32'h0000_F0F0, 32'h0000_FF00);
    wait_done(1, lat);
    check("or_lo", 64'(ALUResult), 64'h0000_FFF0);
    issue(c_mul, 32'd7, 32'd6);
    wait_done(1, lat);
    check("mul76_lo", 64'(ALUResult), 64'd42);
    issue(c_divu, 32'hFFFF_FFFF, 32'd16);
    wait_done(1, lat);
    check("divbig_q", 64'(ALUResult), 64'h0FFF_FFFF);
    check("divbig_r", 64'(ALUResultHi), 64'h0000_000F);
    check("divbig_dbz", 64'(DivByZero), 64'd0);

    tick(); tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
